page_walker: RTL and testbench

PAGE_WALKER -- requirements
Module: page_walker

---
 rtl/page_walker.sv | 144 ++++++++++++++
 tb/tb_page_walker.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/page_walker.sv
// Multi-level page-table walker: fetches one 8-byte PTE per level and returns a PA or a fault.
// Define PAGE_WALKER_SUPERPAGE_EN to accept leaf PTEs above level 0 (superpages).
module page_walker #(
    parameter int SADDR  = 64,
    parameter int SPAGE  = 12,
    parameter int SPCID  = 12,
    parameter int LEVELS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             miss_valid,
    output logic             miss_ready,
    input  logic [SADDR-1:0] miss_va,
    input  logic [SPCID-1:0] miss_pcid,
    input  logic [SADDR-1:0] root,
    output logic             mem_req,
    output logic [SADDR-1:0] mem_addr,
    input  logic             mem_ack,
    input  logic [SADDR-1:0] mem_rdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [SADDR-1:0] resp_pa,
    output logic [SPCID-1:0] resp_pcid,
    output logic             resp_fault,
    input  logic             shutdown
);

    localparam int LW     = (LEVELS > 1) ? $clog2(LEVELS) : 1;
    localparam int VA_TOP = SPAGE + 9 * LEVELS;

`ifdef PAGE_WALKER_SUPERPAGE_EN
    localparam bit SUPERPAGE = 1'b1;
`else
    localparam bit SUPERPAGE = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, REQ, CHECK, DONE, FAULT} state_t;

    state_t          state;
    logic [LW-1:0]   level_q;
    logic [SADDR-1:0] va_q;
    logic [SADDR-1:0] pte_q;
    logic            abort_q;

    function automatic logic [SADDR-1:0] pte_addr(input logic [SADDR-1:0] base,
                                                  input logic [SADDR-1:0] va, input int lvl);
        logic [SADDR-1:0] idx;
        idx = (va >> (SPAGE + 9 * lvl)) & SADDR'(9'h1ff);
        return {base[SADDR-1:SPAGE], {SPAGE{1'b0}}} + (idx << 3);
    endfunction

    // Page bits come from the PTE above the level's offset, the rest from the VA.
    function automatic logic [SADDR-1:0] leaf_pa(input logic [SADDR-1:0] pte,
                                                 input logic [SADDR-1:0] va, input int lvl);
        logic [SADDR-1:0] mask;
        mask = (SADDR'(1) << (SPAGE + 9 * lvl)) - SADDR'(1);
        return (pte & ~mask) | (va & mask);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            miss_ready <= 1'b1;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            resp_pa    <= '0;
            resp_pcid  <= '0;
            level_q    <= '0;
            va_q       <= '0;
            pte_q      <= '0;
            abort_q    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (miss_valid && miss_ready) begin
                        miss_ready <= 1'b0;
                        va_q       <= miss_va;
                        resp_pcid  <= miss_pcid;
                        level_q    <= LW'(LEVELS - 1);
                        abort_q    <= 1'b0;
                        if ((miss_va >> VA_TOP) != '0) begin
                            state      <= FAULT;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_pa    <= '0;
                        end else begin
                            state    <= REQ;
                            mem_req  <= 1'b1;
                            mem_addr <= pte_addr(root, miss_va, LEVELS - 1);
                        end
                    end
                end
                REQ: begin
                    // An aborted read still completes on the bus; its data is dropped.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (abort_q || shutdown) begin
                            state      <= IDLE;
                            miss_ready <= 1'b1;
                        end else begin
                            pte_q <= mem_rdata;
                            state <= CHECK;
                        end
                    end else if (shutdown) begin
                        abort_q <= 1'b1;
                    end
                end
                CHECK: begin
                    if (shutdown) begin
                        state      <= IDLE;
                        miss_ready <= 1'b1;
                    end else if (!pte_q[0] || (!pte_q[1] && level_q == '0) ||
                                 (pte_q[1] && level_q != '0 && !SUPERPAGE)) begin
                        state      <= FAULT;
                        resp_valid <= 1'b1;
                        resp_fault <= 1'b1;
                        resp_pa    <= '0;
                    end else if (pte_q[1]) begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                        resp_fault <= 1'b0;
                        resp_pa    <= leaf_pa(pte_q, va_q, int'(level_q));
                    end else begin
                        state    <= REQ;
                        level_q  <= level_q - LW'(1);
                        mem_req  <= 1'b1;
                        mem_addr <= pte_addr(pte_q, va_q, int'(level_q) - 1);
                    end
                end
                DONE, FAULT: begin
                    if (resp_ready || shutdown) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        miss_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_page_walker.sv
// Directed self-checking bench for page_walker with a small three-entry PTE memory model.
// Expectations for leaf PTEs above level 0 follow PAGE_WALKER_SUPERPAGE_EN.
module tb_page_walker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss_valid = 1'b0;
    logic        miss_ready;
    logic [63:0] miss_va = '0;
    logic [11:0] miss_pcid = '0;
    logic [63:0] root = '0;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_pa;
    logic [11:0] resp_pcid;
    logic        resp_fault;
    logic        shutdown = 1'b0;

    int checks = 0;
    int errors = 0;

    page_walker #(.SADDR(64), .SPAGE(12), .SPCID(12), .LEVELS(3)) dut (
        .clk(clk), .rst(rst), .miss_valid(miss_valid), .miss_ready(miss_ready),
        .miss_va(miss_va), .miss_pcid(miss_pcid), .root(root), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_pa(resp_pa),
        .resp_pcid(resp_pcid), .resp_fault(resp_fault), .shutdown(shutdown)
    );

    always #5 clk = ~clk;

    // Memory model: ack after ack_delay waiting cycles (0 = same cycle as request).
    logic [63:0] a0 = 64'h1008, a1 = 64'h2008, a2 = 64'h3018;
    logic [63:0] d0 = '0, d1 = '0, d2 = '0;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    logic        force_ack = 1'b0;

    assign mem_ack   = (mem_req && (wait_cnt >= ack_delay)) || force_ack;
    assign mem_rdata = (mem_addr == a0) ? d0 : (mem_addr == a1) ? d1 :
                       (mem_addr == a2) ? d2 : 64'h0;

    always @(posedge clk) wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;

    int          rd_cnt = 0, req_cyc = 0, rv_cyc = 0, stab_err = 0, resp_err = 0;
    logic [63:0] rd_addr [8];
    logic        p_req = 0, p_ack = 0, p_rv = 0, p_rr = 0, p_sd = 0, p_fault = 0;
    logic [63:0] p_addr = '0, p_pa = '0;

    always @(posedge clk) begin
        if (mem_req && mem_ack) begin
            if (rd_cnt < 8) rd_addr[rd_cnt] = mem_addr;
            rd_cnt++;
        end
        if (mem_req) req_cyc++;
        if (resp_valid) rv_cyc++;
        if (!rst && p_req && !p_ack && (mem_req !== 1'b1 || mem_addr !== p_addr)) stab_err++;
        if (!rst && p_rv && !p_rr && !p_sd &&
            (resp_valid !== 1'b1 || resp_pa !== p_pa || resp_fault !== p_fault)) resp_err++;
        p_req   = mem_req && !rst;
        p_ack   = mem_ack;
        p_addr  = mem_addr;
        p_rv    = resp_valid && !rst;
        p_rr    = resp_ready;
        p_sd    = shutdown;
        p_pa    = resp_pa;
        p_fault = resp_fault;
    end

    // Present a miss and return #1 after the accepting edge (that cycle counts as cycle 0).
    task automatic start_walk(input logic [63:0] va, input logic [11:0] pcid,
                              input logic [63:0] rt, input bit keep_valid);
        int n = 0;
        rd_cnt = 0; req_cyc = 0; rv_cyc = 0;
        miss_va = va; miss_pcid = pcid; root = rt; miss_valid = 1'b1;
        while (!miss_ready && n < 50) begin @(posedge clk); #1; n++; end
        checks++;
        if (miss_ready !== 1'b1) begin
            errors++; $display("FAIL accept: miss_ready=%b required 1", miss_ready);
        end
        @(posedge clk); #1;
        if (!keep_valid) miss_valid = 1'b0;
    endtask

    task automatic wait_resp(output int cyc);
        cyc = 1;
        while (!resp_valid && cyc < 300) begin @(posedge clk); #1; cyc++; end
    endtask

    task automatic consume();
        resp_ready = 1'b1; @(posedge clk); #1; resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        checks++;
        if ({mem_req, resp_valid, resp_fault} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: req/valid/fault=%b required 000",
                               {mem_req, resp_valid, resp_fault});
        end
        checks++;
        if (mem_addr !== 64'h0 || resp_pa !== 64'h0) begin
            errors++; $display("FAIL reset_addr: mem_addr=%h resp_pa=%h required 0", mem_addr, resp_pa);
        end
        checks++;
        if (resp_pcid !== 12'h0) begin
            errors++; $display("FAIL reset_pcid: got %h required 0", resp_pcid);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (miss_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: miss_ready=%b required 1", miss_ready);
        end
    endtask

    task automatic test_full_walk();
        int cyc;
        d0 = 64'h2001; d1 = 64'h3001; d2 = 64'h7777_7003; ack_delay = 0;
        start_walk(64'h4020_3ABC, 12'h5A5, 64'h1000, 1'b0);
        wait_resp(cyc);
        checks++;
        if (cyc !== 7) begin errors++; $display("FAIL full_latency: got %0d required 7", cyc); end
        checks++;
        if (resp_valid !== 1'b1 || resp_fault !== 1'b0) begin
            errors++; $display("FAIL full_flags: valid=%b fault=%b required 1 0", resp_valid, resp_fault);
        end
        checks++;
        if (resp_pa !== 64'h7777_7ABC) begin
            errors++; $display("FAIL full_pa: got %h required 77777abc", resp_pa);
        end
        checks++;
        if (resp_pcid !== 12'h5A5) begin
            errors++; $display("FAIL full_pcid: got %h required 5a5", resp_pcid);
        end
        checks++;
        if (rd_cnt !== 3 || rd_addr[0] !== 64'h1008 || rd_addr[1] !== 64'h2008 ||
            rd_addr[2] !== 64'h3018) begin
            errors++; $display("FAIL full_addrs: n=%0d %h %h %h required 3 1008 2008 3018",
                               rd_cnt, rd_addr[0], rd_addr[1], rd_addr[2]);
        end
        checks++;
        if (miss_ready !== 1'b0) begin errors++; $display("FAIL full_busy: miss_ready=%b required 0", miss_ready); end
        consume();
        checks++;
        if (miss_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL full_idle: ready=%b valid=%b required 1 0", miss_ready, resp_valid);
        end
    endtask

    task automatic test_superpage();
        int cyc;
        d0 = 64'h2001; d1 = 64'h40_0003; d2 = 64'h7777_7003; ack_delay = 0;
        start_walk(64'h4020_3ABC, 12'h011, 64'h1000, 1'b0);
        wait_resp(cyc);
        checks++;
`ifdef PAGE_WALKER_SUPERPAGE_EN
        if (resp_valid !== 1'b1 || resp_fault !== 1'b0 || resp_pa !== 64'h40_3ABC) begin
            errors++; $display("FAIL super_resp: valid=%b fault=%b pa=%h required 1 0 403abc",
                               resp_valid, resp_fault, resp_pa);
        end
`else
        if (resp_valid !== 1'b1 || resp_fault !== 1'b1 || resp_pa !== 64'h0) begin
            errors++; $display("FAIL super_resp: valid=%b fault=%b pa=%h required 1 1 0",
                               resp_valid, resp_fault, resp_pa);
        end
`endif
        checks++;
        if (rd_cnt !== 2) begin errors++; $display("FAIL super_reads: got %0d required 2", rd_cnt); end
        consume();
    endtask

    task automatic test_faults();
        int cyc;
        d0 = 64'h2000; ack_delay = 0;
        start_walk(64'h4020_3ABC, 12'h022, 64'h1000, 1'b0);
        wait_resp(cyc);
        checks++;
        if (resp_valid !== 1'b1 || resp_fault !== 1'b1 || resp_pa !== 64'h0 || rd_cnt !== 1) begin
            errors++; $display("FAIL invalid_pte: valid=%b fault=%b pa=%h reads=%0d required 1 1 0 1",
                               resp_valid, resp_fault, resp_pa, rd_cnt);
        end
        consume();
        start_walk(64'h80_0000_0000, 12'h033, 64'h1000, 1'b0);
        wait_resp(cyc);
        checks++;
        if (resp_valid !== 1'b1 || resp_fault !== 1'b1 || resp_pa !== 64'h0) begin
            errors++; $display("FAIL bad_va: valid=%b fault=%b pa=%h required 1 1 0",
                               resp_valid, resp_fault, resp_pa);
        end
        checks++;
        if (req_cyc !== 0) begin errors++; $display("FAIL bad_va_mem: req cycles=%0d required 0", req_cyc); end
        consume();
    endtask

    task automatic test_slow_mem();
        int cyc = 1, mr_hi = 0;
        d0 = 64'h2001; d1 = 64'h3001; d2 = 64'h7777_7003; ack_delay = 5;
        stab_err = 0; resp_err = 0;
        start_walk(64'h4020_3ABC, 12'h044, 64'h1000, 1'b1);
        miss_va = 64'h0123_4000;  // extra miss held high mid-walk must be ignored
        while (!resp_valid && cyc < 300) begin
            if (miss_ready) mr_hi++;
            @(posedge clk); #1; cyc++;
        end
        miss_valid = 1'b0;
        repeat (3) begin
            if (miss_ready) mr_hi++;
            @(posedge clk); #1;
        end
        checks++;
        if (resp_valid !== 1'b1 || resp_pa !== 64'h7777_7ABC || resp_fault !== 1'b0) begin
            errors++; $display("FAIL slow_resp: valid=%b pa=%h fault=%b required 1 77777abc 0",
                               resp_valid, resp_pa, resp_fault);
        end
        checks++;
        if (stab_err !== 0) begin errors++; $display("FAIL slow_addr_stable: %0d violations required 0", stab_err); end
        checks++;
        if (resp_err !== 0) begin errors++; $display("FAIL slow_resp_stable: %0d violations required 0", resp_err); end
        checks++;
        if (mr_hi !== 0) begin errors++; $display("FAIL slow_busy: miss_ready high %0d cycles required 0", mr_hi); end
        checks++;
        if (rd_cnt !== 3 || rd_addr[2] !== 64'h3018) begin
            errors++; $display("FAIL slow_reads: n=%0d last=%h required 3 3018", rd_cnt, rd_addr[2]);
        end
        consume();
        checks++;
        if (miss_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL slow_idle: ready=%b valid=%b required 1 0", miss_ready, resp_valid);
        end
    endtask

    task automatic test_shutdown();
        int n = 0, cyc;
        d0 = 64'h2001; d1 = 64'h3001; d2 = 64'h7777_7003; ack_delay = 3;
        start_walk(64'h4020_3ABC, 12'h055, 64'h1000, 1'b0);
        while (!(rd_cnt == 1 && mem_req) && n < 100) begin @(posedge clk); #1; n++; end
        shutdown = 1'b1; @(posedge clk); #1; shutdown = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 64'h2008) begin
            errors++; $display("FAIL sd_hold: req=%b addr=%h required 1 2008", mem_req, mem_addr);
        end
        n = 0;
        while (rd_cnt < 2 && n < 100) begin @(posedge clk); #1; n++; end
        checks++;
        if (mem_req !== 1'b0 || miss_ready !== 1'b1) begin
            errors++; $display("FAIL sd_idle: req=%b ready=%b required 0 1", mem_req, miss_ready);
        end
        repeat (3) @(posedge clk); #1;
        checks++;
        if (rv_cyc !== 0 || rd_cnt !== 2) begin
            errors++; $display("FAIL sd_noresp: valid cycles=%0d reads=%0d required 0 2", rv_cyc, rd_cnt);
        end
        ack_delay = 0;
        start_walk(64'h4020_3ABC, 12'h066, 64'h1000, 1'b0);
        wait_resp(cyc);
        shutdown = 1'b1; @(posedge clk); #1; shutdown = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || miss_ready !== 1'b1) begin
            errors++; $display("FAIL sd_done: valid=%b ready=%b required 0 1", resp_valid, miss_ready);
        end
    endtask

    task automatic test_reset_mid();
        ack_delay = 10;
        start_walk(64'h4020_3ABC, 12'h077, 64'h1000, 1'b0);
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 64'h0) begin
            errors++; $display("FAIL rst_mid_mem: req=%b addr=%h required 0 0", mem_req, mem_addr);
        end
        checks++;
        if ({resp_valid, resp_fault} !== 2'b00 || resp_pa !== 64'h0 || resp_pcid !== 12'h0) begin
            errors++; $display("FAIL rst_mid_resp: valid=%b fault=%b pa=%h pcid=%h required 0",
                               resp_valid, resp_fault, resp_pa, resp_pcid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        force_ack = 1'b1; @(posedge clk); #1; force_ack = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (miss_ready !== 1'b1 || mem_req !== 1'b0 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL stray_ack: ready=%b req=%b valid=%b required 1 0 0",
                               miss_ready, mem_req, resp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_full_walk();
        test_superpage();
        test_faults();
        test_slow_mem();
        test_shutdown();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
